// File: rtl/mult_seq_param.sv
// Sequential shift-and-add multiplier, one multiplier bit per CALC cycle.
// Signed operands are multiplied as magnitudes; the sign is applied in FIX.
module mult_seq_param #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE_ST
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   b_raw_q, b_raw_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] a_long_q, a_long_d;
    logic [WIDTH-1:0]   b_long_q, b_long_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   mag_a, mag_b;

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly the magnitude wanted when read as unsigned.
    always_comb begin
        mag_a = (sgn_q && a_raw_q[WIDTH-1]) ? -a_raw_q : a_raw_q;
        mag_b = (sgn_q && b_raw_q[WIDTH-1]) ? -b_raw_q : b_raw_q;
    end

    always_comb begin
        state_d  = state_q;
        a_raw_d  = a_raw_q;
        b_raw_d  = b_raw_q;
        sgn_d    = sgn_q;
        a_long_d = a_long_q;
        b_long_d = b_long_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (init) begin
                    a_raw_d = op_a;
                    b_raw_d = op_b;
                    sgn_d   = signed_mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_long_d = {{WIDTH{1'b0}}, mag_a};
                b_long_d = mag_b;
                acc_d    = '0;
                count_d  = CW'(WIDTH);
                neg_d    = sgn_q & (a_raw_q[WIDTH-1] ^ b_raw_q[WIDTH-1]);
                state_d  = CALC;
            end
            CALC: begin
                if (b_long_q[0]) begin
                    acc_d = acc_q + a_long_q;
                end
                a_long_d = a_long_q << 1;
                b_long_d = b_long_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_d == '0 || (EARLY_EXIT && b_long_d == '0)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = neg_q ? -acc_q : acc_q;
                state_d  = DONE_ST;
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_raw_q  <= '0;
            b_raw_q  <= '0;
            sgn_q    <= 1'b0;
            a_long_q <= '0;
            b_long_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_raw_q  <= a_raw_d;
            b_raw_q  <= b_raw_d;
            sgn_q    <= sgn_d;
            a_long_q <= a_long_d;
            b_long_q <= b_long_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign DONE   = (state_q == DONE_ST);

endmodule

// File: tb/tb_mult_seq_param.sv
// Bench for mult_seq_param: a 16-bit full-iteration instance and an 8-bit
// early-exit instance, checked every cycle against an arithmetic model.
module tb_mult_seq_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        init16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] res16;
    logic        busy16, done16;

    logic        init8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mult_seq_param #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut16 (
        .clk(clk), .reset(reset), .init(init16), .signed_mode(sm16),
        .op_a(a16), .op_b(b16), .result(res16), .busy(busy16), .DONE(done16)
    );

    mult_seq_param #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut8 (
        .clk(clk), .reset(reset), .init(init8), .signed_mode(sm8),
        .op_a(a8), .op_b(b8), .result(res8), .busy(busy8), .DONE(done8)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: product by plain integer arithmetic, timing from the latency rule.
    function automatic logic [63:0] model_prod(int w, bit sm, logic [31:0] a, logic [31:0] b);
        longint      x, y, mask;
        logic [63:0] m;
        mask = (longint'(1) << w) - 1;
        x = longint'(a) & mask;
        y = longint'(b) & mask;
        if (sm && a[w-1]) x = x - (longint'(1) << w);
        if (sm && b[w-1]) y = y - (longint'(1) << w);
        m = 64'(x * y);
        if (2 * w < 64) m = m & ((64'(1) << (2 * w)) - 1);
        return m;
    endfunction

    function automatic int model_n(int w, bit ee, bit sm, logic [31:0] b);
        longint y;
        int     n;
        if (!ee) return w;
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && b[w-1]) y = (longint'(1) << w) - y;
        n = 1;
        for (int i = 0; i < w; i++) if (y[i]) n = i + 1;
        return n;
    endfunction

    bit          m_idle [2] = '{1'b1, 1'b1};
    int          m_done [2] = '{-1, -1};
    int          m_end  [2] = '{-1, -1};
    logic [63:0] m_prod [2] = '{64'd0, 64'd0};
    logic [63:0] m_res  [2] = '{64'd0, 64'd0};

    task automatic model_edge(int i, int w, bit ee, bit in_init, bit sm,
                              logic [31:0] a, logic [31:0] b);
        int n;
        if (m_idle[i] && in_init) begin
            m_idle[i] = 1'b0;
            m_prod[i] = model_prod(w, sm, a, b);
            n         = model_n(w, ee, sm, b);
            m_done[i] = cyc + n + 2;
            m_end[i]  = cyc + n + 3;
        end else if (!m_idle[i]) begin
            if (cyc == m_done[i]) m_res[i] = m_prod[i];
            if (cyc == m_end[i])  m_idle[i] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_idle[i] = 1'b1;
                m_done[i] = -1;
                m_end[i]  = -1;
                m_res[i]  = 64'd0;
            end
        end else begin
            cyc++;
            model_edge(0, 16, 1'b0, init16, sm16, 32'(a16), 32'(b16));
            model_edge(1, 8,  1'b1, init8,  sm8,  32'(a8),  32'(b8));
        end
    end

    always @(negedge clk) begin
        check("busy16",   64'(busy16), 64'(!m_idle[0]));
        check("done16",   64'(done16), 64'(!m_idle[0] && cyc >= m_done[0]));
        check("result16", 64'(res16),  m_res[0]);
        check("busy8",    64'(busy8),  64'(!m_idle[1]));
        check("done8",    64'(done8),  64'(!m_idle[1] && cyc >= m_done[1]));
        check("result8",  64'(res8),   m_res[1]);
    end

    task automatic start(int i, bit sm, logic [31:0] a, logic [31:0] b, output int k);
        @(posedge clk); #1;
        if (i == 0) begin init16 = 1'b1; sm16 = sm; a16 = a[15:0]; b16 = b[15:0]; end
        else        begin init8  = 1'b1; sm8  = sm; a8  = a[7:0];  b8  = b[7:0];  end
        @(posedge clk); #1;
        k = cyc;
        // Operands wander after the sampling edge; the operation must not care.
        if (i == 0) begin init16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~sm; end
        else        begin init8  = 1'b0; a8  = 8'($urandom);  b8  = 8'($urandom);  sm8  = ~sm; end
    endtask

    task automatic wait_done(int i, output int e);
        bit got;
        got = 1'b0;
        e   = -1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(posedge clk); #1;
            if ((i == 0) ? done16 : done8) begin
                got = 1'b1;
                e   = cyc;
            end
        end
        check("done_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        int k, e, d1, d2, seen;

        #22 reset = 1'b0;
        check("rst_busy",   64'(busy16), 64'd0);
        check("rst_done",   64'(done16), 64'd0);
        check("rst_result", 64'(res16),  64'd0);
        check("rst_noX",    64'($isunknown({res16, busy16, done16, res8, busy8, done8})), 64'd0);

        // Signed -100 x 1000.
        start(0, 1'b1, 32'(-100), 32'd1000, k);
        wait_done(0, e);
        check("lat_signed",   64'(e - k), 64'd18);
        check("res_signed",   64'(res16), 64'hFFFE7960);

        // Unsigned all-ones squared.
        start(0, 1'b0, 32'h0000FFFF, 32'h0000FFFF, k);
        wait_done(0, e);
        check("res_unsigned", 64'(res16), 64'hFFFE0001);

        // init pulsed during CALC is ignored.
        start(0, 1'b1, 32'(-100), 32'd1000, k);
        repeat (5) @(posedge clk);
        #1 init16 = 1'b1; sm16 = 1'b0; a16 = 16'd7; b16 = 16'd7;
        @(posedge clk); #1 init16 = 1'b0;
        wait_done(0, e);
        check("ignore_lat", 64'(e - k), 64'd18);
        check("ignore_res", 64'(res16), 64'hFFFE7960);
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (done16) seen++; end
        check("ignore_single_done", 64'(seen), 64'd0);

        // Back-to-back with init held high.
        @(posedge clk); #1;
        init16 = 1'b1; sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000;
        wait_done(0, d1);
        check("b2b_res1", 64'(res16), 64'h40000000);
        a16 = 16'hFFFF; b16 = 16'h0001;
        wait_done(0, d2);
        init16 = 1'b0;
        check("b2b_gap",  64'(d2 - (d1 + 1)), 64'd19);
        check("b2b_res2", 64'(res16), 64'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #1 check("b2b_idle", 64'(busy16), 64'd0);

        // Reset during the 5th CALC cycle aborts without a DONE.
        start(0, 1'b1, 32'(-100), 32'd1000, k);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy",   64'(busy16), 64'd0);
        check("abort_result", 64'(res16),  64'd0);
        check("abort_done",   64'(done16), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (done16) seen++; end
        check("abort_no_done", 64'(seen), 64'd0);
        start(0, 1'b0, 32'd3, 32'd4, k);
        wait_done(0, e);
        check("fresh_lat", 64'(e - k), 64'd18);
        check("fresh_res", 64'(res16), 64'd12);

        // Early-exit instance.
        start(1, 1'b0, 32'd5, 32'd3, k);
        wait_done(1, e);
        check("ee_lat",  64'(e - k), 64'd4);
        check("ee_res",  64'(res8),  64'h000F);
        start(1, 1'b0, 32'd5, 32'd0, k);
        wait_done(1, e);
        check("ee_zero_lat", 64'(e - k), 64'd3);
        check("ee_zero_res", 64'(res8),  64'h0000);
        start(1, 1'b1, 32'h80, 32'h80, k);
        wait_done(1, e);
        check("ee_min_lat", 64'(e - k), 64'd10);
        check("ee_min_res", 64'(res8),  64'h4000);
        start(1, 1'b1, 32'hFD, 32'h02, k);
        wait_done(1, e);
        check("ee_neg_lat", 64'(e - k), 64'd4);
        check("ee_neg_res", 64'(res8),  64'hFFFA);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
